// File: rtl/p2s_serializer_buf_if.sv
// p2s_serializer_buf_if: parallel word handshake plus serial beat handshake
interface p2s_serializer_buf_if #(parameter int N = 8, parameter int W = 1);
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         msb_first;
  logic         p_ready;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic [1:0]   occupancy;
  modport master (output p_data, p_valid, msb_first, s_ready,
                  input  p_ready, s_data, s_valid, s_last, occupancy);
  modport slave  (input  p_data, p_valid, msb_first, s_ready,
                  output p_ready, s_data, s_valid, s_last, occupancy);
endinterface

// File: rtl/p2s_serializer_buf.sv
// p2s_serializer_buf: N-bit words to W-bit beats with a one-word holding buffer
module p2s_serializer_buf #(
  parameter int N = 8,
  parameter int W = 1
) (
  input logic                clk,
  input logic                rstn,
  p2s_serializer_buf_if.slave bus
);
  localparam int B  = N / W;
  localparam int CW = $clog2(B);
  logic [N-1:0]  shift;
  logic [N-1:0]  hold;
  logic          act_msb;
  logic          hold_msb;
  logic          act_v;
  logic          hold_v;
  logic [CW-1:0] cnt;
  logic          p_fire;
  logic          s_fire;
  logic          done;
  assign bus.p_ready   = !hold_v;
  assign bus.s_valid   = act_v;
  assign bus.s_last    = act_v & (cnt == CW'(B - 1));
  assign bus.s_data    = act_msb ? shift[N-1 -: W] : shift[W-1:0];
  assign bus.occupancy = {1'b0, act_v} + {1'b0, hold_v};
  assign p_fire = bus.p_valid & !hold_v;
  assign s_fire = act_v & bus.s_ready;
  assign done   = s_fire & bus.s_last;
  // Active/hold stage update: refill the active stage on the last beat, otherwise shift and queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift    <= '0;
      hold     <= '0;
      act_msb  <= 1'b0;
      hold_msb <= 1'b0;
      act_v    <= 1'b0;
      hold_v   <= 1'b0;
      cnt      <= '0;
    end else if (done) begin
      cnt <= '0;
      if (hold_v) begin
        shift   <= hold;
        act_msb <= hold_msb;
        hold_v  <= 1'b0;
      end else if (p_fire) begin
        shift   <= bus.p_data;
        act_msb <= bus.msb_first;
      end else begin
        act_v <= 1'b0;
      end
    end else begin
      if (s_fire) begin
        shift <= act_msb ? shift << W : shift >> W;
        cnt   <= cnt + CW'(1);
      end
      if (p_fire && !act_v) begin
        shift   <= bus.p_data;
        act_msb <= bus.msb_first;
        act_v   <= 1'b1;
        cnt     <= '0;
      end else if (p_fire) begin
        hold     <= bus.p_data;
        hold_msb <= bus.msb_first;
        hold_v   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_p2s_serializer_buf.sv
// tb_p2s_serializer_buf: directed and random checks against a beat-queue reference model
module tb_p2s_serializer_buf;
  localparam int N = 8;
  localparam int W = 1;
  localparam int B = N / W;
  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } beat_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  beat_t q[$];
  int occ = 0;
  int span = 0;
  int sv_cnt = 0;
  bit acc;
  p2s_serializer_buf_if #(.N(N), .W(W)) bus ();
  p2s_serializer_buf_if #(.N(8), .W(2)) bus2 ();
  p2s_serializer_buf_if #(.N(8), .W(4)) bus4 ();
  p2s_serializer_buf #(.N(N), .W(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  p2s_serializer_buf #(.N(8), .W(2)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));
  p2s_serializer_buf #(.N(8), .W(4)) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_word(input logic [N-1:0] w, input bit m);
    beat_t bt;
    for (int i = 0; i < B; i++) begin
      bt.d    = m ? w[N-1-i*W -: W] : w[i*W +: W];
      bt.last = (i == B - 1);
      q.push_back(bt);
    end
  endtask
  task automatic step(output bit accepted);
    bit pf;
    bit sf;
    #1;
    chk("s_valid", {31'b0, bus.s_valid}, {31'b0, occ != 0});
    chk("p_ready", {31'b0, bus.p_ready}, {31'b0, occ < 2});
    chk("occupancy", {30'b0, bus.occupancy}, occ);
    if (occ != 0) begin
      chk("s_data", {{(32-W){1'b0}}, bus.s_data}, {{(32-W){1'b0}}, q[0].d});
      chk("s_last", {31'b0, bus.s_last}, {31'b0, q[0].last});
    end else
      chk("s_last_idle", {31'b0, bus.s_last}, 32'd0);
    span++;
    if (bus.s_valid === 1'b1) sv_cnt++;
    pf = bus.p_valid && occ < 2;
    sf = occ != 0 && bus.s_ready;
    if (sf) begin
      if (q[0].last) occ--;
      void'(q.pop_front());
    end
    if (pf) begin
      push_word(bus.p_data, bus.msb_first);
      occ++;
    end
    accepted = pf;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wait_acc(input string tag);
    int n = 0;
    bit a = 1'b0;
    while (!a && n < 100) begin
      step(a);
      n++;
    end
    chk(tag, {31'b0, a}, 32'd1);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    bit a;
    bus.p_valid = 1'b0;
    bus.s_ready = 1'b1;
    while (occ != 0 && n < 200) begin
      step(a);
      n++;
    end
    #1;
    chk(tag, {30'b0, bus.occupancy}, 32'd0);
    @(negedge clk);
  endtask
  initial begin
    logic [1:0] e2 [4];
    logic [3:0] e4 [4];
    e2 = '{2'b10, 2'b11, 2'b01, 2'b00};
    e4 = '{4'h0, 4'h1, 4'h1, 4'h0};
    bus.p_valid = 1'b0; bus.p_data = '0; bus.msb_first = 1'b0; bus.s_ready = 1'b1;
    bus2.p_valid = 1'b0; bus2.p_data = '0; bus2.msb_first = 1'b0; bus2.s_ready = 1'b1;
    bus4.p_valid = 1'b0; bus4.p_data = '0; bus4.msb_first = 1'b0; bus4.s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_valid", {31'b0, bus.s_valid}, 32'd0);
    chk("rst_s_last", {31'b0, bus.s_last}, 32'd0);
    chk("rst_s_data", {31'b0, bus.s_data}, 32'd0);
    chk("rst_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("rst_p_ready", {31'b0, bus.p_ready}, 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    // single word, LSB first
    bus.p_data = 8'hB4; bus.msb_first = 1'b0; bus.p_valid = 1'b1;
    wait_acc("t1_accept");
    drain("t1_drain");
    // back-to-back streaming must leave no bubble
    bus.p_data = 8'hA5; bus.p_valid = 1'b1; bus.s_ready = 1'b1;
    wait_acc("t3_accept0");
    span = 0;
    sv_cnt = 0;
    bus.p_data = 8'h3C;
    wait_acc("t3_accept1");
    bus.p_data = 8'hFF;
    wait_acc("t3_accept2");
    drain("t3_drain");
    chk("t3_span", span, 32'd24);
    chk("t3_sv_cycles", sv_cnt, 32'd24);
    // backpressure until full, then release
    bus.s_ready = 1'b0;
    bus.p_data = 8'h5A; bus.msb_first = 1'b1; bus.p_valid = 1'b1;
    wait_acc("t4_accept0");
    bus.p_data = 8'hC3; bus.msb_first = 1'b0;
    wait_acc("t4_accept1");
    bus.p_data = 8'hFF;
    for (int i = 0; i < 4; i++) step(acc);
    chk("t4_full_occ", {30'b0, bus.occupancy}, 32'd2);
    drain("t4_drain");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.p_valid   = 1'($urandom_range(0, 1));
      bus.p_data    = N'($urandom);
      bus.msb_first = 1'($urandom_range(0, 1));
      bus.s_ready   = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    drain("rand_drain");
    // reset while a word is shifting and another is held
    bus.p_data = 8'h96; bus.msb_first = 1'b0; bus.p_valid = 1'b1; bus.s_ready = 1'b1;
    wait_acc("t6_accept0");
    bus.p_data = 8'hE1;
    wait_acc("t6_accept1");
    bus.p_valid = 1'b0;
    step(acc);
    step(acc);
    #2 rstn = 1'b0;
    #1;
    chk("t6_s_valid", {31'b0, bus.s_valid}, 32'd0);
    chk("t6_s_last", {31'b0, bus.s_last}, 32'd0);
    chk("t6_s_data", {31'b0, bus.s_data}, 32'd0);
    chk("t6_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("t6_p_ready", {31'b0, bus.p_ready}, 32'd1);
    q.delete();
    occ = 0;
    @(negedge clk);
    rstn = 1'b1;
    bus.p_data = 8'h6B; bus.msb_first = 1'b1; bus.p_valid = 1'b1;
    wait_acc("t6_accept2");
    drain("t6_drain");
    // W=2, MSB first
    bus2.p_data = 8'hB4; bus2.msb_first = 1'b1; bus2.p_valid = 1'b1;
    #1;
    chk("w2_pre_valid", {31'b0, bus2.s_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus2.p_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w2_s_valid", {31'b0, bus2.s_valid}, 32'd1);
      chk("w2_s_data", {30'b0, bus2.s_data}, {30'b0, e2[i]});
      chk("w2_s_last", {31'b0, bus2.s_last}, {31'b0, i == 3});
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("w2_end_valid", {31'b0, bus2.s_valid}, 32'd0);
    chk("w2_end_occ", {30'b0, bus2.occupancy}, 32'd0);
    @(negedge clk);
    // W=4, order flag captured per word
    bus4.p_data = 8'h01; bus4.msb_first = 1'b1; bus4.p_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.msb_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bus4.p_valid = 1'b0;
      #1;
      chk("w4_s_valid", {31'b0, bus4.s_valid}, 32'd1);
      chk("w4_s_data", {28'b0, bus4.s_data}, {28'b0, e4[i]});
      chk("w4_s_last", {31'b0, bus4.s_last}, {31'b0, i == 1 || i == 3});
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("w4_end_valid", {31'b0, bus4.s_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
